// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-select adder/subtractor, one BLOCK-bit slice
// per pipeline stage, valid/ready handshake with a full-pipeline stall.
module csa_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned SW   = BLOCK + 1;

  // Elaboration-time guard against illegal slicing.
  if ((WIDTH % BLOCK) != 0 || NBLK == 0) begin : g_bad_cfg
    $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Per-stage pipeline registers; element k belongs to stage k.
  logic             vld_q [NBLK];
  logic             cry_q [NBLK];
  logic             sub_q [NBLK];
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic [WIDTH-1:0] sum_q [NBLK];
  logic             ovf_q;
  logic             en_c;

  // Whole pipeline advances unless a valid result is waiting on the consumer.
  assign en_c    = ~vld_q[NBLK-1] | i_ready;
  assign o_ready = en_c;

  assign o_valid = vld_q[NBLK-1];
  assign o_sum   = sum_q[NBLK-1];
  assign o_cout  = cry_q[NBLK-1];
  assign o_ovf   = ovf_q;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    localparam int unsigned LO = k * BLOCK;

    logic             in_vld;
    logic             in_cry;
    logic             in_sub;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_sum;
    logic [BLOCK-1:0] a_s;
    logic [BLOCK-1:0] b_s;
    logic [SW-1:0]    r0;
    logic [SW-1:0]    r1;
    logic [SW-1:0]    sel;
    logic [WIDTH-1:0] sum_d;
    logic             cry_d;

    // Stage 0 takes the raw handshake inputs; later stages take the stage below.
    if (k == 0) begin : g_src
      assign in_vld = i_valid;
      assign in_cry = i_cin ^ i_sub;
      assign in_sub = i_sub;
      assign in_a   = i_add_term1;
      assign in_b   = i_add_term2;
      assign in_sum = '0;
    end else begin : g_src
      assign in_vld = vld_q[k-1];
      assign in_cry = cry_q[k-1];
      assign in_sub = sub_q[k-1];
      assign in_a   = a_q[k-1];
      assign in_b   = b_q[k-1];
      assign in_sum = sum_q[k-1];
    end

    // Both carry-in variants of this slice, selected by the carry from below.
    assign a_s   = in_a[LO +: BLOCK];
    assign b_s   = in_b[LO +: BLOCK] ^ {BLOCK{in_sub}};
    assign r0    = SW'(a_s) + SW'(b_s);
    assign r1    = SW'(a_s) + SW'(b_s) + SW'(1'b1);
    assign sel   = in_cry ? r1 : r0;
    assign cry_d = sel[BLOCK];

    // Merge this slice's sum bits into the partial sum carried along.
    always_comb begin
      sum_d             = in_sum;
      sum_d[LO +: BLOCK] = sel[BLOCK-1:0];
    end

    // Stage register: clears on reset, shifts (bubbles included) when enabled.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        sub_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end else if (en_c) begin
        vld_q[k] <= in_vld;
        cry_q[k] <= cry_d;
        sub_q[k] <= in_sub;
        a_q[k]   <= in_a;
        b_q[k]   <= in_b;
        sum_q[k] <= sum_d;
      end
    end

    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    if (k == NBLK - 1) begin : g_ovf
      logic msb_cin;
      logic ovf_d;

      assign msb_cin = in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ in_sub ^ sel[BLOCK-1];
      assign ovf_d   = msb_cin ^ cry_d;

      // Overflow flag travels with the last stage.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ovf_q <= 1'b0;
        end else if (en_c) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed scenarios on a 16/4 instance plus a
// randomized regression over several WIDTH/BLOCK configurations.
module tb_csa_pipe_adder;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned BLOCK    = 4;
  localparam int unsigned LAT      = 4;
  localparam int unsigned NCFG     = 4;
  localparam int unsigned RAND_TXN = 2500;
  localparam int unsigned CFG_W [NCFG] = '{16, 32, 4, 12};
  localparam int unsigned CFG_B [NCFG] = '{4, 8, 4, 3};

  logic        clk;
  logic        rst;
  logic        vld_in;
  logic        rdy_out;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin_in;
  logic        sub_in;
  logic        vld_out;
  logic        rdy_in;
  logic [15:0] sum_out;
  logic        cout_out;
  logic        ovf_out;
  logic        rnd_go;

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  csa_pipe_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (vld_in),
    .o_ready    (rdy_out),
    .i_add_term1(a_in),
    .i_add_term2(b_in),
    .i_cin      (cin_in),
    .i_sub      (sub_in),
    .o_valid    (vld_out),
    .i_ready    (rdy_in),
    .o_sum      (sum_out),
    .o_cout     (cout_out),
    .o_ovf      (ovf_out)
  );

  // Random regression instances, one per configuration, each with its own model.
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned GW = CFG_W[g];
    localparam int unsigned GB = CFG_B[g];

    logic          g_rst, g_vi, g_ro, g_vo, g_ri, g_cin, g_sub, g_cout, g_ovf;
    logic [GW-1:0] g_a, g_b, g_sum;
    logic [GW+1:0] exp_q [$];
    logic          done;

    csa_pipe_adder #(.WIDTH(GW), .BLOCK(GB)) u_dut (
      .i_clk      (clk),
      .i_rst      (g_rst),
      .i_valid    (g_vi),
      .o_ready    (g_ro),
      .i_add_term1(g_a),
      .i_add_term2(g_b),
      .i_cin      (g_cin),
      .i_sub      (g_sub),
      .o_valid    (g_vo),
      .i_ready    (g_ri),
      .o_sum      (g_sum),
      .o_cout     (g_cout),
      .o_ovf      (g_ovf)
    );

    initial begin : drive
      logic [GW+1:0] e;
      logic          m_cout, m_ovf;
      longint        ua, ub, sa, sb, ures, sres, smax, smin;
      int            acc, cyc;
      done  = 1'b0;
      g_rst = 1'b1;
      g_vi  = 1'b0;
      g_ri  = 1'b1;
      g_a   = '0;
      g_b   = '0;
      g_cin = 1'b0;
      g_sub = 1'b0;
      acc   = 0;
      cyc   = 0;
      smax  = (longint'(1) << (GW - 1)) - 1;
      smin  = -(longint'(1) << (GW - 1));
      repeat (3) @(negedge clk);
      g_rst = 1'b0;
      wait (rnd_go);
      while ((acc < int'(RAND_TXN) || exp_q.size() != 0) && cyc < 20000) begin
        @(negedge clk);
        g_vi  = (acc < int'(RAND_TXN)) && ($urandom_range(0, 3) != 0);
        g_a   = GW'($urandom);
        g_b   = GW'($urandom);
        g_cin = 1'($urandom);
        g_sub = 1'($urandom);
        g_ri  = ($urandom_range(0, 3) != 0);
        #1;
        if (g_vo && g_ri) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL cfg%0d_extra: got unexpected result sum=%h expected none", g, g_sum);
          end else begin
            e = exp_q.pop_front();
            if ({g_ovf, g_cout, g_sum} !== e) begin
              n_err++;
              $display("FAIL cfg%0d_result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                       g, g_ovf, g_cout, g_sum, e[GW+1], e[GW], e[GW-1:0]);
            end
          end
        end
        if (g_vi && g_ro) begin
          ua = longint'(g_a);
          ub = longint'(g_b);
          sa = longint'($signed(g_a));
          sb = longint'($signed(g_b));
          if (!g_sub) begin
            ures   = ua + ub + longint'(g_cin);
            sres   = sa + sb + longint'(g_cin);
            m_cout = (ures >= (longint'(1) << GW));
          end else begin
            ures   = ua - ub - longint'(g_cin);
            sres   = sa - sb - longint'(g_cin);
            m_cout = (ures >= 0);
          end
          m_ovf = (sres > smax) || (sres < smin);
          exp_q.push_back({m_ovf, m_cout, GW'(ures)});
          acc++;
        end
        cyc++;
      end
      g_vi = 1'b0;
      n_cmp++;
      if (acc != int'(RAND_TXN) || exp_q.size() != 0) begin
        n_err++;
        $display("FAIL cfg%0d_drain: got accepted=%0d pending=%0d expected accepted=%0d pending=0",
                 g, acc, exp_q.size(), RAND_TXN);
      end
      done = 1'b1;
    end
  end

  // Apply one vector to an idle pipeline and sample around the expected latency.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output logic [15:0] s, output logic co,
                         output logic ov, output logic v_early, output logic v_at,
                         output logic v_after);
    @(negedge clk);
    vld_in = 1'b1;
    a_in   = a;
    b_in   = b;
    cin_in = cin;
    sub_in = sub;
    @(negedge clk);
    vld_in = 1'b0;
    a_in   = 16'($urandom);
    b_in   = 16'($urandom);
    cin_in = 1'($urandom);
    sub_in = 1'($urandom);
    repeat (LAT - 2) @(negedge clk);
    v_early = vld_out;
    @(negedge clk);
    v_at = vld_out;
    s    = sum_out;
    co   = cout_out;
    ov   = ovf_out;
    @(negedge clk);
    v_after = vld_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (vld_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", vld_out); end
    n_cmp++;
    if ({sum_out, cout_out, ovf_out} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_data: got sum=%h cout=%b ovf=%b expected 0", sum_out, cout_out, ovf_out);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rdy_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", rdy_out); end
  endtask

  task automatic test_add_wrap();
    logic [15:0] s;
    logic co, ov, ve, va, vn;
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, ve, va, vn);
    n_cmp++;
    if (ve !== 1'b0) begin n_err++; $display("FAIL wrap_early: got valid=%b expected 0", ve); end
    n_cmp++;
    if (va !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b expected 1", va); end
    n_cmp++;
    if ({s, co, ov} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL wrap_result: got sum=%h cout=%b ovf=%b expected sum=0000 cout=1 ovf=0", s, co, ov);
    end
    n_cmp++;
    if (vn !== 1'b0) begin n_err++; $display("FAIL wrap_one_cycle: got valid=%b expected 0", vn); end
  endtask

  task automatic test_sub_ovf();
    logic [15:0] s;
    logic co, ov, ve, va, vn;
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, ve, va, vn);
    n_cmp++;
    if ({va, s, co, ov} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL sub_ovf: got v=%b sum=%h cout=%b ovf=%b expected v=1 sum=7fff cout=1 ovf=1", va, s, co, ov);
    end
    run_one(16'h0000, 16'h0001, 1'b0, 1'b1, s, co, ov, ve, va, vn);
    n_cmp++;
    if ({va, s, co, ov} !== {1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_borrow: got v=%b sum=%h cout=%b ovf=%b expected v=1 sum=ffff cout=0 ovf=0", va, s, co, ov);
    end
  endtask

  task automatic test_carry_chain();
    logic [15:0] s;
    logic co, ov, ve, va, vn;
    run_one(16'h0FFF, 16'h0001, 1'b1, 1'b0, s, co, ov, ve, va, vn);
    n_cmp++;
    if ({va, s, co, ov} !== {1'b1, 16'h1001, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL chain_cin: got v=%b sum=%h cout=%b ovf=%b expected v=1 sum=1001 cout=0 ovf=0", va, s, co, ov);
    end
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, ve, va, vn);
    n_cmp++;
    if ({va, s, co, ov} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL chain_ovf: got v=%b sum=%h cout=%b ovf=%b expected v=1 sum=8000 cout=0 ovf=1", va, s, co, ov);
    end
  endtask

  task automatic test_backpressure();
    int sent, got, c, extra;
    sent = 0;
    got  = 0;
    c    = 0;
    while ((sent < 8 || got < 8) && c < 40) begin
      @(negedge clk);
      rdy_in = !(c >= 5 && c <= 7);
      vld_in = (sent < 8);
      a_in   = 16'(sent + 1);
      b_in   = 16'(2 * (sent + 1));
      cin_in = 1'b0;
      sub_in = 1'b0;
      #1;
      if (c >= 5 && c <= 7) begin
        n_cmp++;
        if (rdy_out !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready c=%0d: got %b expected 0", c, rdy_out); end
      end
      if (vld_out && rdy_in) begin
        n_cmp++;
        if (sum_out !== 16'(3 * (got + 1))) begin
          n_err++;
          $display("FAIL bp_order #%0d: got sum=%h expected %h", got, sum_out, 16'(3 * (got + 1)));
        end
        got++;
      end
      if (vld_in && rdy_out) sent++;
      c++;
    end
    vld_in = 1'b0;
    rdy_in = 1'b1;
    n_cmp++;
    if (sent != 8 || got != 8) begin
      n_err++;
      $display("FAIL bp_count: got sent=%0d received=%0d expected 8/8", sent, got);
    end
    extra = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (vld_out) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_err++; $display("FAIL bp_duplicate: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s;
    logic co, ov, ve, va, vn;
    int stale;
    rdy_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vld_in = 1'b1;
      a_in   = 16'($urandom);
      b_in   = 16'($urandom);
      cin_in = 1'($urandom);
      sub_in = 1'($urandom);
    end
    @(negedge clk);
    vld_in = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (vld_out !== 1'b0 || sum_out !== 16'h0) begin
      n_err++;
      $display("FAIL rstmid_clear: got valid=%b sum=%h expected valid=0 sum=0000", vld_out, sum_out);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rdy_out !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", rdy_out); end
    stale = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (vld_out) stale++;
    end
    n_cmp++;
    if (stale != 0) begin n_err++; $display("FAIL rstmid_stale: got %0d stale results expected 0", stale); end
    run_one(16'h1234, 16'h0F0F, 1'b0, 1'b0, s, co, ov, ve, va, vn);
    n_cmp++;
    if ({ve, va, s, co, ov} !== {1'b0, 1'b1, 16'h2143, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_latency: got early=%b v=%b sum=%h cout=%b ovf=%b expected early=0 v=1 sum=2143 cout=0 ovf=0",
               ve, va, s, co, ov);
    end
  endtask

  task automatic test_random();
    int t;
    rnd_go = 1'b1;
    t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 30000) begin n_err++; $display("FAIL random_timeout: got %0d cycles expected completion", t); end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rnd_go = 1'b0;
    rst    = 1'b1;
    vld_in = 1'b0;
    rdy_in = 1'b1;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
    sub_in = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub_ovf();
    test_carry_chain();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor, the next-generation replacement for the fixed 4-bit carry-select adder in the adder library. Operands are split into BLOCK-bit slices. Each slice precomputes both carry-in variants and selects one using the registered carry of the slice below, with one pipeline stage per slice. A valid/ready handshake with full-pipeline stall lets it sit between streaming producers and consumers in the classification datapath.

## Interface
Parameters:
- WIDTH, 16: operand and sum width; must be a multiple of BLOCK.
- BLOCK, 4: slice width; NBLK = WIDTH/BLOCK is the number of pipeline stages (NBLK ≥ 1).

Ports (the reset is synchronous and active-high):
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  adder can accept input this cycle.
- i_add_term1  in  WIDTH  operand A.
- i_add_term2  in  WIDTH  operand B.
- i_cin  in  1  carry-in (add) / borrow-in (sub).
- i_sub  in  1  1 = A − B, 0 = A + B.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result this cycle.
- o_sum  out  WIDTH  result.
- o_cout  out  1  carry out of MSB (sub: 1 = no borrow).
- o_ovf  out  1  two's-complement signed overflow.

## Operation
- Effective operand B' = i_sub ? ~i_add_term2 : i_add_term2. Effective carry-in c0 = i_cin XOR i_sub. Result = A + B' + c0, taken mod 2^WIDTH.
- Stage k (0..NBLK−1) holds one registered valid bit, the carry out of slice k, and the partial sum bits [(k+1)·BLOCK−1:0].
- Stage k also holds the skewed operand bits for slices > k and i_sub.
- Slice k computes s0/c0 (carry-in 0) and s1/c1 (carry-in 1) from its delayed operands. The registered carry from stage k−1 (c0 for k = 0) selects between them.
- o_sum, o_cout, o_valid are the stage NBLK−1 registers directly; no combinational path from inputs to these outputs.
- o_ovf = carry into MSB XOR carry out of MSB. It is registered with the last stage.
- Global advance enable en = ~o_valid | i_ready. When en = 1, all stages shift by one; bubbles (valid = 0) shift too. When en = 0, all stages hold.
- o_ready = en. An input is accepted iff i_valid & o_ready.
- A result is consumed iff o_valid & i_ready.
- Results leave in acceptance order; none are dropped or duplicated.
- Reset: all valid bits clear to 0. o_valid = 0, o_sum = 0, o_cout = 0, o_ovf = 0. All datapath registers clear to 0.
- Reset mid-operation discards all in-flight results. o_ready is 1 in the first cycle after i_rst deasserts.
- Operands are sampled only on acceptance. Input values while not accepted are don't-care and must not affect results.

## Timing
- Latency is NBLK cycles: a vector accepted at edge t appears on o_valid/o_sum after edge t+NBLK−1. That is NBLK cycles after the cycle in which i_valid & o_ready was high.
- With NBLK = 1 the block is a single registered adder with latency 1.
- Throughput is one result per cycle when i_ready is held high.
- Stall: i_ready low with o_valid high freezes the whole pipeline; o_ready drops in that same cycle (combinational from i_ready).
- If o_valid = 0, the pipeline advances regardless of i_ready, so bubbles collapse from the output end only.
- Simultaneous accept and consume in one cycle is legal and keeps full throughput.
- Critical path: one BLOCK-bit slice plus a 2:1 mux per stage. No stage may chain carries through more than one slice.

## Test plan
Default WIDTH = 16, BLOCK = 4, latency 4 unless stated.
- Add wrap: A = 0xFFFF, B = 0x0001, cin = 0, sub = 0 → 4 cycles later o_sum = 0x0000, o_cout = 1, o_ovf = 0, o_valid = 1 for exactly one cycle.
- Subtract overflow: A = 0x8000, B = 0x0001, sub = 1, cin = 0 → o_sum = 0x7FFF, o_cout = 1, o_ovf = 1. Then A = 0x0000, B = 0x0001 → o_sum = 0xFFFF, o_cout = 0, o_ovf = 0.
- Carry across every slice boundary: A = 0x0FFF, B = 0x0001, cin = 1 → o_sum = 0x1001. Also A = 0x7FFF, B = 0x0001 → 0x8000, o_ovf = 1.
- Backpressure: stream 8 back-to-back vectors (A = i, B = 2i) with i_ready low on cycles 5–7 → exactly 8 outputs, in order, o_sum = 3i. o_ready is low on the stalled cycles.
- Reset mid-stream: assert i_rst with 3 vectors in flight → next cycle o_valid = 0, o_sum = 0. No stale result appears afterwards; the first post-reset vector has latency 4.
- Random regression vs. behavioural model:
  - Configurations (16,4), (32,8), (4,4) and (12,3).
  - Random i_valid/i_ready, i_sub and i_cin.
  - Compare sum, cout and ovf for 10k transactions.
